// File: rtl/mul_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_accel_pkg
//  Description : Shared constants for the multiplier accelerator: register
//                offsets, control/status bit positions and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_accel_pkg;

    // Register offsets on the slave bus
    localparam logic [7:0] c_ADDR_OPA    = 8'h00;
    localparam logic [7:0] c_ADDR_OPB    = 8'h01;
    localparam logic [7:0] c_ADDR_CTRL   = 8'h02;
    localparam logic [7:0] c_ADDR_STATUS = 8'h03;
    localparam logic [7:0] c_ADDR_INTEN  = 8'h04;
    localparam logic [7:0] c_ADDR_RIDX   = 8'h05;
    localparam logic [7:0] c_ADDR_RESLO  = 8'h06;
    localparam logic [7:0] c_ADDR_RESHI  = 8'h07;

    // CTRL bit positions
    localparam int c_CTRL_START  = 0;
    localparam int c_CTRL_CLEAR  = 1;
    localparam int c_CTRL_SIGNED = 2;

    // STATUS bit positions
    localparam int c_STAT_DONE    = 0;
    localparam int c_STAT_BUSY    = 1;
    localparam int c_STAT_AFULL   = 2;
    localparam int c_STAT_BFULL   = 3;
    localparam int c_STAT_OVF     = 4;
    localparam int c_STAT_CNT_LSB = 8;
    localparam int c_STAT_CNT_W   = 4;

    // Engine FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_POP   = 3'd1;
    localparam state_t c_ST_EXEC  = 3'd2;
    localparam state_t c_ST_WRITE = 3'd3;
    localparam state_t c_ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mul_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mul_fifo
//  Description : Show-ahead operand FIFO. dout always presents the oldest
//                entry; a push into a full FIFO is accepted only when a pop
//                frees the slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = rd_en && (r_count != '0);
    assign w_push = wr_en && ((r_count != c_FULL) || w_pop);
    assign dout   = r_mem[r_rd_ptr];
    assign empty  = (r_count == '0);
    assign full   = (r_count == c_FULL);

    // Storage array; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; indices wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_accel.sv
`default_nettype none
// ============================================================================
//  Module      : mul_accel
//  Description : Bus-slave multiplier accelerator. Operand pairs are drained
//                from two FIFOs by an iterative shift-add engine (one
//                multiplier bit per cycle) into a 2*WIDTH result buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_accel
    import mul_accel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             S_sel,
    input  logic             S_wr,
    input  logic [7:0]       S_address,
    input  logic [WIDTH-1:0] S_din,
    output logic [WIDTH-1:0] S_dout,
    output logic             m_interrupt
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_BW       = $clog2(WIDTH);
    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(WIDTH - 1);

    // Bus decode
    logic w_wr;
    logic w_rd;
    logic w_push_a;
    logic w_push_b;
    logic w_ctrl_wr;
    logic w_opstart;
    logic w_opclear;
    logic w_fifo_rst;

    // FIFO interface
    logic [WIDTH-1:0] w_a_dout;
    logic [WIDTH-1:0] w_b_dout;
    logic             w_a_empty;
    logic             w_b_empty;
    logic             w_a_full;
    logic             w_b_full;

    // FSM
    state_t r_state;
    state_t w_state_nxt;
    logic   w_pair_ready;
    logic   w_busy;
    logic   w_done;
    logic   w_pop;
    logic   w_exec;
    logic   w_write;

    // Engine
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [c_BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_product;

    // Result buffer and registers
    logic [WIDTH-1:0] r_res_lo [DEPTH];
    logic [WIDTH-1:0] r_res_hi [DEPTH];
    logic [c_AW:0]    r_res_cnt;
    logic             r_int_en;
    logic             r_signed;
    logic             r_ovf;
    logic [c_AW-1:0]  r_ridx;
    logic             w_ovf_set;
    logic [WIDTH-1:0] w_status_flags;
    logic [WIDTH-1:0] w_status_cnt;
    logic [WIDTH-1:0] w_status;
    logic [WIDTH-1:0] w_rdata;

    assign w_wr       = S_sel && S_wr;
    assign w_rd       = S_sel && !S_wr;
    assign w_push_a   = w_wr && (S_address == c_ADDR_OPA);
    assign w_push_b   = w_wr && (S_address == c_ADDR_OPB);
    assign w_ctrl_wr  = w_wr && (S_address == c_ADDR_CTRL);
    assign w_opstart  = w_ctrl_wr && S_din[c_CTRL_START];
    assign w_opclear  = w_ctrl_wr && S_din[c_CTRL_CLEAR];
    assign w_fifo_rst = reset || w_opclear;

    // A pair can only be taken when both operands exist and the buffer has room
    assign w_pair_ready = !w_a_empty && !w_b_empty && (r_res_cnt != c_CNT_FULL);

    // A push that finds the FIFO full (and no pop freeing a slot) is lost
    assign w_ovf_set = (w_push_a && w_a_full && !w_pop) ||
                       (w_push_b && w_b_full && !w_pop);

    assign m_interrupt = w_done && r_int_en;

    mul_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .reset (w_fifo_rst),
        .wr_en (w_push_a),
        .rd_en (w_pop),
        .din   (S_din),
        .dout  (w_a_dout),
        .empty (w_a_empty),
        .full  (w_a_full)
    );

    mul_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .reset (w_fifo_rst),
        .wr_en (w_push_b),
        .rd_en (w_pop),
        .din   (S_din),
        .dout  (w_b_dout),
        .empty (w_b_empty),
        .full  (w_b_full)
    );

    // State register; opclear aborts from any state and beats a same-cycle opstart
    always_ff @(posedge clk) begin
        if (reset || w_opclear) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_opstart) w_state_nxt = c_ST_POP;
            c_ST_POP:   w_state_nxt = w_pair_ready ? c_ST_EXEC : c_ST_DONE;
            c_ST_EXEC:  if (r_bit_cnt == c_LAST_BIT) w_state_nxt = c_ST_WRITE;
            c_ST_WRITE: w_state_nxt = c_ST_POP;
            c_ST_DONE:  w_state_nxt = c_ST_DONE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_pop   = 1'b0;
        w_exec  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            c_ST_POP: begin
                w_busy = 1'b1;
                w_pop  = w_pair_ready;
            end
            c_ST_EXEC: begin
                w_busy = 1'b1;
                w_exec = 1'b1;
            end
            c_ST_WRITE: begin
                w_busy  = 1'b1;
                w_write = 1'b1;
            end
            c_ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    // Signed operands are multiplied as magnitudes; -2^(W-1) maps to 2^(W-1),
    // which still fits in WIDTH unsigned bits
    assign w_mag_a = (r_signed && w_a_dout[WIDTH-1]) ? -w_a_dout : w_a_dout;
    assign w_mag_b = (r_signed && w_b_dout[WIDTH-1]) ? -w_b_dout : w_b_dout;

    // Upper half accumulates, lower half holds the unconsumed multiplier bits;
    // the carry out of the add is shifted back into the top
    assign w_addend  = r_acc[0] ? r_mcand : '0;
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_product = r_neg ? -r_acc : r_acc;

    // Iterative shift-add engine: load on pop, one multiplier bit per EXEC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_bit_cnt <= '0;
        end else if (w_pop) begin
            r_mcand   <= w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
            r_neg     <= r_signed && (w_a_dout[WIDTH-1] ^ w_b_dout[WIDTH-1]);
            r_bit_cnt <= '0;
        end else if (w_exec) begin
            r_acc     <= {w_sum, r_acc[WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + c_BW'(1);
        end
    end

    // Result storage, indexed by the current result count
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_res_lo[r_res_cnt[c_AW-1:0]] <= w_product[WIDTH-1:0];
            r_res_hi[r_res_cnt[c_AW-1:0]] <= w_product[2*WIDTH-1:WIDTH];
        end
    end

    // Result count; an opclear discards any product being written this cycle
    always_ff @(posedge clk) begin
        if (reset || w_opclear) begin
            r_res_cnt <= '0;
        end else if (w_write && (r_res_cnt != c_CNT_FULL)) begin
            r_res_cnt <= r_res_cnt + (c_AW + 1)'(1);
        end
    end

    // Software-visible control registers and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_en <= 1'b0;
            r_signed <= 1'b0;
            r_ridx   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr && (S_address == c_ADDR_INTEN)) r_int_en <= S_din[0];
            if (w_wr && (S_address == c_ADDR_RIDX))  r_ridx   <= S_din[c_AW-1:0];
            if (w_opstart && !w_opclear && (r_state == c_ST_IDLE)) begin
                r_signed <= S_din[c_CTRL_SIGNED];
            end
            if (w_opclear) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // STATUS flag bits
    always_comb begin
        w_status_flags              = '0;
        w_status_flags[c_STAT_DONE]  = w_done;
        w_status_flags[c_STAT_BUSY]  = w_busy;
        w_status_flags[c_STAT_AFULL] = w_a_full;
        w_status_flags[c_STAT_BFULL] = w_b_full;
        w_status_flags[c_STAT_OVF]   = r_ovf;
    end

    // The count field only exists when the data bus is wide enough to carry it
    if (WIDTH >= c_STAT_CNT_LSB + c_STAT_CNT_W) begin : g_stat_cnt
        assign w_status_cnt = WIDTH'(c_STAT_CNT_W'(r_res_cnt)) << c_STAT_CNT_LSB;
    end else begin : g_stat_nocnt
        assign w_status_cnt = '0;
    end

    assign w_status = w_status_flags | w_status_cnt;

    // Read data mux; write-only and unmapped offsets read as zero
    always_comb begin
        w_rdata = '0;
        case (S_address)
            c_ADDR_STATUS: w_rdata = w_status;
            c_ADDR_INTEN:  w_rdata = WIDTH'(r_int_en);
            c_ADDR_RIDX:   w_rdata = WIDTH'(r_ridx);
            c_ADDR_RESLO:  w_rdata = r_res_lo[r_ridx];
            c_ADDR_RESHI:  w_rdata = r_res_hi[r_ridx];
            default:       w_rdata = '0;
        endcase
    end

    // Registered read port; holds its last value when no read is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            S_dout <= '0;
        end else if (w_rd) begin
            S_dout <= w_rdata;
        end
    end

endmodule
`default_nettype wire
